// File: rtl/lcd_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_write_sequencer
// Purpose  : Queues command/data words and plays them out as 8080-style
//            parallel write cycles (CS/RS/WR/DATA). Also runs the panel
//            hardware-reset sequence (LCD_RST pulse plus wake-up wait)
//            after HRESET or on an rst_req pulse.
// Ports    : HCLK/HRESET          clock, asynchronous active-high reset
//            in_valid/in_ready    word handshake (in_rs, in_data)
//            rst_req              abort, flush and rerun the panel reset
//            busy/init_done       status, fifo_level = words queued
//            LCD_CS/RS/WR/RD/RST  panel control pins (CS/WR/RD/RST act-low)
//            LCD_DATA             panel data bus
// Revision : 1.0 - initial release
// ============================================================================
module lcd_write_sequencer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYC    = 2,
    parameter int WR_LOW_CYC   = 3,
    parameter int HOLD_CYC     = 2,
    parameter int RST_CYC      = 50000,
    parameter int RST_WAIT_CYC = 6000000
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_rs,
    input  logic [15:0]                 in_data,
    input  logic                        rst_req,
    output logic                        busy,
    output logic                        init_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        LCD_CS,
    output logic                        LCD_RS,
    output logic                        LCD_WR,
    output logic                        LCD_RD,
    output logic                        LCD_RST,
    output logic [15:0]                 LCD_DATA
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int MAX_A   = (SETUP_CYC > WR_LOW_CYC) ? SETUP_CYC : WR_LOW_CYC;
    localparam int MAX_B   = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_MAX = (MAX_C > RST_WAIT_CYC) ? MAX_C : RST_WAIT_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Terminal counts: a state lasting N cycles exits when the counter,
    // cleared on entry, reaches N-1.
    localparam logic [CNT_W-1:0] C_SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_WR_LAST    = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] C_RST_LAST   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] C_WAIT_LAST  = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [LVL_W-1:0] C_FULL       = LVL_W'(FIFO_DEPTH);

    localparam logic [2:0] S_RST_LOW  = 3'd0;
    localparam logic [2:0] S_RST_WAIT = 3'd1;
    localparam logic [2:0] S_IDLE     = 3'd2;
    localparam logic [2:0] S_SETUP    = 3'd3;
    localparam logic [2:0] S_STROBE   = 3'd4;
    localparam logic [2:0] S_HOLD     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cs_q, cs_d;
    logic             wr_q, wr_d;
    logic             rd_q;
    logic             rs_q, rs_d;
    logic [15:0]      data_q, data_d;
    logic             lrst_q, lrst_d;
    logic             rdy_q, rdy_d;
    logic             init_q, init_d;
    logic             busy_q, busy_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [16:0]      mem_q [FIFO_DEPTH];
    logic             push;
    logic             pop;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        cs_d     = cs_q;
        wr_d     = wr_q;
        rs_d     = rs_q;
        data_d   = data_q;
        lrst_d   = lrst_q;
        init_d   = init_q;
        pop      = 1'b0;
        push     = in_valid & rdy_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        case (state_q)
            S_RST_LOW: begin
                if (cnt_q == C_RST_LAST) begin
                    lrst_d  = 1'b1;
                    state_d = S_RST_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RST_WAIT: begin
                if (cnt_q == C_WAIT_LAST) begin
                    init_d  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (lvl_q != '0) begin
                    pop     = 1'b1;
                    cs_d    = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == C_SETUP_LAST) begin
                    wr_d    = 1'b0;
                    state_d = S_STROBE;
                    cnt_d   = '0;
                end
            end
            S_STROBE: begin
                if (cnt_q == C_WR_LAST) begin
                    wr_d    = 1'b1;
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == C_HOLD_LAST) begin
                    cnt_d = '0;
                    // Chain straight into the next word so CS stays low
                    // and there is no idle gap between back-to-back writes.
                    if (lvl_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        cs_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_RST_LOW;
                cnt_d   = '0;
            end
        endcase

        if (pop) begin
            rs_d   = mem_q[rd_ptr_q][16];
            data_d = mem_q[rd_ptr_q][15:0];
        end

        // rst_req overrides everything, including a push in the same cycle
        // and a strobe in progress.
        if (rst_req) begin
            push    = 1'b0;
            pop     = 1'b0;
            state_d = S_RST_LOW;
            cnt_d   = '0;
            wr_d    = 1'b1;
            cs_d    = 1'b1;
            lrst_d  = 1'b0;
            init_d  = 1'b0;
        end

        if (rst_req) begin
            lvl_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            lvl_d = lvl_q + LVL_W'(push) - LVL_W'(pop);
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Status outputs are registered, so they are derived from next state.
        rdy_d  = init_d & (lvl_d != C_FULL) &
                 (state_d != S_RST_LOW) & (state_d != S_RST_WAIT);
        busy_d = (state_d != S_IDLE) | (lvl_d != '0);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= S_RST_LOW;
            cnt_q    <= '0;
            cs_q     <= 1'b1;
            wr_q     <= 1'b1;
            rd_q     <= 1'b1;
            rs_q     <= 1'b0;
            data_q   <= '0;
            lrst_q   <= 1'b0;
            rdy_q    <= 1'b0;
            init_q   <= 1'b0;
            busy_q   <= 1'b1;
            lvl_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cs_q     <= cs_d;
            wr_q     <= wr_d;
            rd_q     <= 1'b1;
            rs_q     <= rs_d;
            data_q   <= data_d;
            lrst_q   <= lrst_d;
            rdy_q    <= rdy_d;
            init_q   <= init_d;
            busy_q   <= busy_d;
            lvl_q    <= lvl_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the level counter defines what is valid.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_rs, in_data};
        end
    end

    assign in_ready   = rdy_q;
    assign busy       = busy_q;
    assign init_done  = init_q;
    assign fifo_level = lvl_q;
    assign LCD_CS     = cs_q;
    assign LCD_RS     = rs_q;
    assign LCD_WR     = wr_q;
    assign LCD_RD     = rd_q;
    assign LCD_RST    = lrst_q;
    assign LCD_DATA   = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_write_sequencer
// Purpose  : Self-checking bench for lcd_write_sequencer. A timeline model
//            assigns each accepted word a start cycle and derives every pin
//            and status value from those start times.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_write_sequencer;

    localparam int DEPTH  = 4;
    localparam int SETUP  = 2;
    localparam int WRL    = 3;
    localparam int HOLD   = 2;
    localparam int RSTC   = 4;
    localparam int RWAIT  = 5;
    localparam int PERIOD = SETUP + WRL + HOLD;

    logic        HCLK     = 1'b0;
    logic        HRESET   = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_rs    = 1'b0;
    logic [15:0] in_data  = 16'h0000;
    logic        rst_req  = 1'b0;
    logic        in_ready, busy, init_done;
    logic [2:0]  fifo_level;
    logic        LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST;
    logic [15:0] LCD_DATA;

    lcd_write_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .SETUP_CYC   (SETUP),
        .WR_LOW_CYC  (WRL),
        .HOLD_CYC    (HOLD),
        .RST_CYC     (RSTC),
        .RST_WAIT_CYC(RWAIT)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs     (in_rs),
        .in_data   (in_data),
        .rst_req   (rst_req),
        .busy      (busy),
        .init_done (init_done),
        .fifo_level(fifo_level),
        .LCD_CS    (LCD_CS),
        .LCD_RS    (LCD_RS),
        .LCD_WR    (LCD_WR),
        .LCD_RD    (LCD_RD),
        .LCD_RST   (LCD_RST),
        .LCD_DATA  (LCD_DATA)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [16:0] w;
        int          s;
    } word_t;

    word_t words[$];
    int    t        = 0;
    int    rbase    = 0;
    int    last_s   = -1000;
    int    n_total  = 0;
    int    n_bad    = 0;
    int    e_lvl    = 0;
    logic  exp_rdy  = 1'b0;
    logic  last_acc = 1'b0;
    logic  e_wr     = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0d)", tag, got, want, t);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cs"},   LCD_CS, 1);
        check({tag, "_wr"},   LCD_WR, 1);
        check({tag, "_rd"},   LCD_RD, 1);
        check({tag, "_rs"},   LCD_RS, 0);
        check({tag, "_data"}, LCD_DATA, 0);
        check({tag, "_lrst"}, LCD_RST, 0);
        check({tag, "_rdy"},  in_ready, 0);
        check({tag, "_init"}, init_done, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_lvl"},  fifo_level, 0);
    endtask

    // One clock edge: update the timeline model with the inputs that were
    // presented, then compare every output shortly after the edge.
    task automatic step();
        word_t       ent;
        logic        cs_e, act, init_e, lrst_e, busy_e;
        logic [16:0] dat_e;
        int          lvl;
        @(posedge HCLK);
        t++;
        last_acc = in_valid && exp_rdy && !rst_req;
        if (rst_req) begin
            words.delete();
            last_s = -1000;
            rbase  = t;
        end else if (last_acc) begin
            ent.w  = {in_rs, in_data};
            // A word starts one cycle after acceptance, or when the previous
            // word's full write period ends, whichever is later.
            ent.s  = (t + 1 > last_s + PERIOD) ? t + 1 : last_s + PERIOD;
            last_s = ent.s;
            words.push_back(ent);
        end
        while (words.size() > 0 && words[0].s + PERIOD <= t) words.delete(0);

        lvl   = 0;
        cs_e  = 1'b1;
        e_wr  = 1'b1;
        act   = 1'b0;
        dat_e = '0;
        foreach (words[i]) begin
            if (words[i].s > t) begin
                lvl++;
            end else begin
                act   = 1'b1;
                cs_e  = 1'b0;
                dat_e = words[i].w;
                if (t >= words[i].s + SETUP && t < words[i].s + SETUP + WRL) e_wr = 1'b0;
            end
        end
        init_e  = (t >= rbase + RSTC + RWAIT);
        lrst_e  = (t >= rbase + RSTC);
        exp_rdy = init_e && (lvl < DEPTH);
        busy_e  = !init_e || (lvl > 0) || act;
        e_lvl   = lvl;

        #1;
        check("cs",    LCD_CS, cs_e);
        check("wr",    LCD_WR, e_wr);
        check("rd",    LCD_RD, 1);
        check("lrst",  LCD_RST, lrst_e);
        check("init",  init_done, init_e);
        check("rdy",   in_ready, exp_rdy);
        check("busy",  busy, busy_e);
        check("level", fifo_level, lvl);
        if (!cs_e) check("rs_data", {LCD_RS, LCD_DATA}, dat_e);
    endtask

    task automatic random_cycles(input int n);
        int dens;
        dens = 60;
        for (int i = 0; i < n; i++) begin
            if (i % 100 == 0) dens = $urandom_range(20, 95);
            in_valid = ($urandom_range(0, 99) < dens);
            in_rs    = $urandom_range(0, 1);
            in_data  = 16'($urandom);
            rst_req  = ($urandom_range(0, 199) == 0);
            step();
        end
        in_valid = 1'b0;
        rst_req  = 1'b0;
    endtask

    initial begin
        int cnt;

        // Reset state while HRESET is held; in_valid is already high and
        // stays high through the panel reset sequence.
        in_valid = 1'b1;
        in_rs    = 1'b0;
        in_data  = 16'h002C;
        repeat (2) @(posedge HCLK);
        #1;
        check_reset_values("por");
        @(negedge HCLK);
        HRESET = 1'b0;
        rbase  = t;

        // Single command word 002C, accepted the cycle in_ready rises.
        cnt = 0;
        while (!last_acc && cnt < 30) begin
            step();
            cnt++;
        end
        if (!last_acc) check("first_accept_timeout", 0, 1);
        in_valid = 1'b0;
        repeat (12) step();

        // Back-to-back burst, longer than the FIFO.
        cnt = 0;
        in_valid = 1'b1;
        {in_rs, in_data} = 17'($urandom);
        for (int i = 0; i < 60 && cnt < 6; i++) begin
            step();
            if (last_acc) begin
                cnt++;
                {in_rs, in_data} = 17'($urandom);
            end
        end
        if (cnt < 6) check("burst_timeout", cnt, 6);
        in_valid = 1'b0;
        repeat (45) step();

        // Abort with WR low and three words queued; a same-cycle push is dropped.
        cnt = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 30 && cnt < 4; i++) begin
            {in_rs, in_data} = 17'($urandom);
            step();
            if (last_acc) cnt++;
        end
        in_valid = 1'b0;
        cnt = 0;
        while (!(e_wr == 1'b0 && e_lvl == 3) && cnt < 40) begin
            step();
            cnt++;
        end
        if (cnt >= 40) check("abort_setup_timeout", 0, 1);
        rst_req  = 1'b1;
        in_valid = 1'b1;
        step();
        rst_req  = 1'b0;
        in_valid = 1'b0;
        repeat (14) step();

        random_cycles(1500);

        // Asynchronous HRESET in the middle of a strobe.
        cnt = 0;
        in_valid = 1'b1;
        step();
        while (e_wr != 1'b0 && cnt < 60) begin
            {in_rs, in_data} = 17'($urandom);
            step();
            cnt++;
        end
        if (cnt >= 60) check("async_setup_timeout", 0, 1);
        in_valid = 1'b0;
        #2;
        HRESET = 1'b1;
        #1;
        check_reset_values("async");
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        words.delete();
        last_s  = -1000;
        rbase   = t;
        exp_rdy = 1'b0;

        random_cycles(300);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
